// File: rtl/mul_frac_pipe_if.sv
// Operand/result handshake bundle for mul_frac_pipe.
// master = operand source + result consumer, slave = the multiplier.
interface mul_frac_pipe_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             round_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] p_o;
  logic             valid_o;
  logic             ready_i;

  modport master (
    output a_i, b_i, round_i, valid_i, ready_i,
    input  ready_o, p_o, valid_o
  );

  modport slave (
    input  a_i, b_i, round_i, valid_i, ready_i,
    output ready_o, p_o, valid_o
  );
endinterface

// File: rtl/mul_frac_pipe.sv
// Pipelined fractional multiplier returning the high half of a*b.
//  - SIGNED=0: unsigned Q0.W, p = (a*b [+2^(W-1)]) >> W
//  - SIGNED=1: Q1.(W-1),      p = (a*b [+2^(W-2)]) >>> (W-1), saturated to 2^(W-1)-1
// The operand-capture edge loads the first of STAGES accumulation registers;
// partial-product rows are spread ceil(W/STAGES) per stage, and a final
// register holds the shifted/saturated result, so a sample accepted at edge N
// appears after edge N+STAGES. One global enable stalls the whole pipe.
// Optional build macro MUL_FRAC_OVF_EN adds ovf_o / ovf_cnt_o.
module mul_frac_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3,
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          rst,
  mul_frac_pipe_if.slave bus
`ifdef MUL_FRAC_OVF_EN
  ,
  output logic          ovf_o,
  output logic [15:0]   ovf_cnt_o
`endif
);

  localparam int W2 = 2 * WIDTH;
  localparam int R  = (WIDTH + STAGES - 1) / STAGES;   // rows per stage
  // Rounding constant is injected as the accumulator seed, so it costs no extra adder row.
  localparam logic [W2-1:0] RND_K = (SIGNED != 0) ? (W2'(1) << (WIDTH - 2))
                                                  : (W2'(1) << (WIDTH - 1));

  logic                          w_en;
  logic [STAGES:0]               r_vld_pipe;
  logic [STAGES-1:0][W2-1:0]     r_acc;
  logic [STAGES-1:0][WIDTH-1:0]  r_a;
  logic [STAGES-1:0][WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]              r_p;

  logic [W2-1:0]                 w_acc0;
  logic [STAGES:0][W2-1:0]       w_acc_src;
  logic [STAGES:0][WIDTH-1:0]    w_a_src;
  logic [STAGES:0][WIDTH-1:0]    w_b_src;
  logic [STAGES-1:0][W2-1:0]     w_acc_nxt;
  logic [W2-1:0]                 w_ext;
  logic [W2-1:0]                 w_sum;
  logic [W2-1:0]                 w_fin;
  logic [WIDTH-1:0]              w_p;
  logic                          w_ovf;
  logic                          w_unused;

  // Whole pipe moves unless the output holds an unconsumed sample.
  assign w_en        = !r_vld_pipe[STAGES] || bus.ready_i;
  assign bus.ready_o = w_en;
  assign bus.valid_o = r_vld_pipe[STAGES];
  assign bus.p_o     = r_p;

  // Stage k reads source index k: index 0 is the live input, k>0 the previous stage.
  assign w_acc0    = bus.round_i ? RND_K : '0;
  assign w_acc_src = {r_acc, w_acc0};
  assign w_a_src   = {r_a, bus.a_i};
  assign w_b_src   = {r_b, bus.b_i};

  // Per-stage partial-product rows; the signed MSB row carries negative weight.
  always_comb begin
    w_acc_nxt = '0;
    w_ext     = '0;
    w_sum     = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_ext = (SIGNED != 0) ? {{WIDTH{w_a_src[k][WIDTH-1]}}, w_a_src[k]}
                            : {{WIDTH{1'b0}}, w_a_src[k]};
      w_sum = w_acc_src[k];
      for (int j = 0; j < R; j++) begin
        if (k * R + j < WIDTH) begin
          if (w_b_src[k][k*R+j]) begin
            if ((SIGNED != 0) && (k * R + j == WIDTH - 1))
              w_sum = w_sum - (w_ext << (k * R + j));
            else
              w_sum = w_sum + (w_ext << (k * R + j));
          end
        end
      end
      w_acc_nxt[k] = w_sum;
    end
  end

  assign w_fin = r_acc[STAGES-1];

  // Select the result window; signed overflow shows as sign=0 with bit 2W-2 set.
  always_comb begin
    w_ovf = 1'b0;
    w_p   = w_fin[W2-1:WIDTH];
    if (SIGNED != 0) begin
      if (!w_fin[W2-1] && w_fin[W2-2]) begin
        w_ovf = 1'b1;
        w_p   = {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        w_p   = w_fin[W2-2:WIDTH-1];
      end
    end
  end

  // Operands of the last stage and the discarded low product bits go nowhere.
  assign w_unused = ^{w_a_src[STAGES], w_b_src[STAGES], w_fin[WIDTH-2:0], w_ovf};

  // Pipeline registers: valid bits shift with data, everything holds when w_en=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_acc      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_p        <= '0;
    end else if (w_en) begin
      r_vld_pipe[0] <= bus.valid_i;
      for (int i = 1; i <= STAGES; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
      r_acc <= w_acc_nxt;
      r_a   <= w_a_src[STAGES-1:0];
      r_b   <= w_b_src[STAGES-1:0];
      r_p   <= w_p;
    end
  end

`ifdef MUL_FRAC_OVF_EN
  logic        r_ovf;
  logic [15:0] r_ovf_cnt;

  // Saturation flag rides alongside r_p.
  always_ff @(posedge clk) begin
    if (rst)       r_ovf <= 1'b0;
    else if (w_en) r_ovf <= w_ovf;
  end

  // Count saturated samples as they are handed off; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst)
      r_ovf_cnt <= '0;
    else if (r_vld_pipe[STAGES] && bus.ready_i && r_ovf && (r_ovf_cnt != 16'hFFFF))
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
  end

  assign ovf_o     = r_ovf;
  assign ovf_cnt_o = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_mul_frac_pipe.sv
// Bench for mul_frac_pipe: directed table and corner sequences on W=8/STAGES=3
// unsigned and signed instances, then randomized streams on six configurations
// (SIGNED 0/1 x STAGES 1/3/8) checked against an arithmetic reference model.
module tb_mul_frac_pipe;

  localparam int NV     = 14;
  localparam int N_RAND = 2000;
  localparam int LIMIT  = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d;
  logic rst_r;
  bit   go_rand;
  int   done_cnt;
  int   n_run;
  int   n_fail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_run++;
    n_fail++;
    $display("FAIL %s: required event did not occur as expected", nm);
  endtask

  // Reference: plain integer arithmetic; bit 8 = saturated.
  function automatic logic [8:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                         input logic rnd, input bit sgn);
    int pr;
    int q;
    if (!sgn) begin
      pr = int'(a) * int'(b) + (rnd ? 128 : 0);
      return {1'b0, 8'(pr / 256)};
    end
    pr = int'($signed(a)) * int'($signed(b)) + (rnd ? 64 : 0);
    q  = pr >>> 7;
    if (q > 127) return {1'b1, 8'h7F};
    return {1'b0, 8'(q)};
  endfunction

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 7))
      0:       return 8'h80;
      1:       return 8'h7F;
      2:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  // ---------------- directed instances ----------------
  mul_frac_pipe_if #(.WIDTH(8)) bu();
  mul_frac_pipe_if #(.WIDTH(8)) bs();
`ifdef MUL_FRAC_OVF_EN
  logic        du_ovf, ds_ovf;
  logic [15:0] du_cnt, ds_cnt;
`endif

  mul_frac_pipe #(.WIDTH(8), .STAGES(3), .SIGNED(0)) du (
    .clk(clk), .rst(rst_d), .bus(bu)
`ifdef MUL_FRAC_OVF_EN
    , .ovf_o(du_ovf), .ovf_cnt_o(du_cnt)
`endif
  );

  mul_frac_pipe #(.WIDTH(8), .STAGES(3), .SIGNED(1)) ds (
    .clk(clk), .rst(rst_d), .bus(bs)
`ifdef MUL_FRAC_OVF_EN
    , .ovf_o(ds_ovf), .ovf_cnt_o(ds_cnt)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       rnd;
    logic [7:0] pu;   // unsigned result
    logic [7:0] ps;   // signed result
    logic       ovs;  // signed saturated
  } vec_t;

  vec_t       tbl [NV];
  logic [7:0] bp_exp [4];

  task automatic drv(input logic [7:0] a, input logic [7:0] b, input logic r, input logic v);
    bu.a_i = a; bu.b_i = b; bu.round_i = r; bu.valid_i = v;
    bs.a_i = a; bs.b_i = b; bs.round_i = r; bs.valid_i = v;
  endtask

  initial begin
    n_run = 0; n_fail = 0; done_cnt = 0; go_rand = 1'b0;
    tbl[0]  = '{8'h45, 8'h55, 1'b0, 8'h16, 8'h2D, 1'b0};
    tbl[1]  = '{8'h55, 8'h65, 1'b0, 8'h21, 8'h43, 1'b0};
    tbl[2]  = '{8'h45, 8'h55, 1'b1, 8'h17, 8'h2E, 1'b0};
    tbl[3]  = '{8'h55, 8'h65, 1'b1, 8'h22, 8'h43, 1'b0};
    tbl[4]  = '{8'hFF, 8'hFF, 1'b1, 8'hFE, 8'h00, 1'b0};
    tbl[5]  = '{8'h40, 8'h40, 1'b0, 8'h10, 8'h20, 1'b0};
    tbl[6]  = '{8'h40, 8'hC0, 1'b0, 8'h30, 8'hE0, 1'b0};
    tbl[7]  = '{8'h80, 8'h80, 1'b0, 8'h40, 8'h7F, 1'b1};
    tbl[8]  = '{8'h80, 8'h80, 1'b1, 8'h40, 8'h7F, 1'b1};
    tbl[9]  = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 8'h00, 1'b0};
    tbl[10] = '{8'h80, 8'h7F, 1'b0, 8'h3F, 8'h81, 1'b0};
    tbl[11] = '{8'h00, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b0};
    tbl[12] = '{8'h7F, 8'h7F, 1'b1, 8'h3F, 8'h7E, 1'b0};
    tbl[13] = '{8'h80, 8'h01, 1'b0, 8'h00, 8'hFF, 1'b0};
    bp_exp[0] = 8'h01; bp_exp[1] = 8'h04; bp_exp[2] = 8'h09; bp_exp[3] = 8'h10;

    // Reset state
    rst_d = 1'b1; rst_r = 1'b1;
    drv(8'h00, 8'h00, 1'b0, 1'b0);
    bu.ready_i = 1'b0; bs.ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_u", bu.valid_o, 0); chk("rst_p_u", bu.p_o, 0); chk("rst_ready_u", bu.ready_o, 1);
    chk("rst_valid_s", bs.valid_o, 0); chk("rst_p_s", bs.p_o, 0); chk("rst_ready_s", bs.ready_o, 1);
`ifdef MUL_FRAC_OVF_EN
    chk("rst_ovf", ds_ovf, 0); chk("rst_cnt", ds_cnt, 0);
`endif
    @(negedge clk);
    rst_d = 1'b0; rst_r = 1'b0;

    // Table: back-to-back samples, both DUTs, latency = acceptance + 3 edges
    begin
      int gu;
      int gs;
      gu = 0; gs = 0;
      for (int c = 0; c < NV + 8; c++) begin
        @(negedge clk);
        bu.ready_i = 1'b1; bs.ready_i = 1'b1;
        if (c < NV) drv(tbl[c].a, tbl[c].b, tbl[c].rnd, 1'b1);
        else        drv(8'h00, 8'h00, 1'b0, 1'b0);
        #1;
        if (bu.valid_o) begin
          if (gu < NV) begin
            chk($sformatf("tbl%0d_u_p", gu), bu.p_o, tbl[gu].pu);
            chk($sformatf("tbl%0d_u_lat", gu), c, gu + 4);
`ifdef MUL_FRAC_OVF_EN
            chk($sformatf("tbl%0d_u_ovf", gu), du_ovf, 0);
`endif
          end
          gu++;
        end
        if (bs.valid_o) begin
          if (gs < NV) begin
            chk($sformatf("tbl%0d_s_p", gs), bs.p_o, tbl[gs].ps);
            chk($sformatf("tbl%0d_s_lat", gs), c, gs + 4);
`ifdef MUL_FRAC_OVF_EN
            chk($sformatf("tbl%0d_s_ovf", gs), ds_ovf, tbl[gs].ovs);
`endif
          end
          gs++;
        end
      end
      chk("tbl_u_count", gu, NV);
      chk("tbl_s_count", gs, NV);
`ifdef MUL_FRAC_OVF_EN
      chk("ovf_cnt_s", ds_cnt, 2);
      chk("ovf_cnt_u", du_cnt, 0);
`endif
    end

    // Backpressure: stall 5 cycles once the first result appears
    begin
      int idx, nout, stall, first_c;
      bit stalled;
      idx = 0; nout = 0; stall = 0; first_c = 0; stalled = 1'b0;
      for (int c = 0; c < 24; c++) begin
        @(negedge clk);
        if (!stalled && bu.valid_o) begin stalled = 1'b1; stall = 5; end
        bu.ready_i = (stall == 0);
        bs.ready_i = 1'b1;
        if (idx < 4) drv(8'((idx + 1) * 16), 8'((idx + 1) * 16), 1'b0, 1'b1);
        else         drv(8'h00, 8'h00, 1'b0, 1'b0);
        #1;
        if (stall > 0) begin
          chk("bp_ready_low", bu.ready_o, 0);
          chk("bp_p_held", bu.p_o, 8'h01);
          chk("bp_valid_held", bu.valid_o, 1);
          stall--;
        end
        if (bu.valid_i && bu.ready_o) idx++;
        if (bu.valid_o && bu.ready_i) begin
          if (nout < 4) chk($sformatf("bp_out%0d", nout), bu.p_o, bp_exp[nout]);
          if (nout == 0) first_c = c;
          else           chk($sformatf("bp_cycle%0d", nout), c, first_c + nout);
          nout++;
        end
      end
      chk("bp_stall_seen", stalled, 1);
      chk("bp_accepted", idx, 4);
      chk("bp_out_count", nout, 4);
    end

    // Reset mid-operation: two in flight, third presented with rst
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        bu.ready_i = 1'b1;
        rst_d = (c == 2);
        drv(8'h00, 8'h00, 1'b0, 1'b0);
        if (c == 0) drv(8'hFF, 8'hFF, 1'b0, 1'b1);
        if (c == 1) drv(8'hF0, 8'hF0, 1'b0, 1'b1);
        if (c == 2) drv(8'hE0, 8'hE0, 1'b0, 1'b1);
        if (c == 6) drv(8'h45, 8'h55, 1'b0, 1'b1);
        #1;
        if (c == 3) begin
          chk("mid_rst_valid", bu.valid_o, 0);
          chk("mid_rst_p", bu.p_o, 0);
          chk("mid_rst_ready", bu.ready_o, 1);
        end
        if (c == 10) begin
          chk("mid_rst_new_valid", bu.valid_o, 1);
          chk("mid_rst_new_p", bu.p_o, 8'h16);
        end
        if (bu.valid_o) seen++;
      end
      chk("mid_rst_only_new", seen, 1);
    end

    // Random phase
    go_rand = 1'b1;
    begin
      int w;
      w = 0;
      while (done_cnt < 6 && w < LIMIT + 1000) begin
        @(negedge clk);
        w++;
      end
      if (done_cnt < 6) fail("rnd_done_timeout");
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  // ---------------- randomized configurations ----------------
  for (genvar g = 0; g < 6; g++) begin : g_rnd
    localparam int SG = g / 3;
    localparam int ST = (g % 3 == 0) ? 1 : ((g % 3 == 1) ? 3 : 8);

    mul_frac_pipe_if #(.WIDTH(8)) bus();
`ifdef MUL_FRAC_OVF_EN
    logic        ovf;
    logic [15:0] cnt;
`endif

    mul_frac_pipe #(.WIDTH(8), .STAGES(ST), .SIGNED(SG)) dut (
      .clk(clk), .rst(rst_r), .bus(bus)
`ifdef MUL_FRAC_OVF_EN
      , .ovf_o(ovf), .ovf_cnt_o(cnt)
`endif
    );

    logic [8:0] q [$];

    initial begin
      int         acc_n, chk_n, cyc, ocnt;
      logic [8:0] e;
      acc_n = 0; chk_n = 0; cyc = 0; ocnt = 0;
      bus.a_i = '0; bus.b_i = '0; bus.round_i = 1'b0; bus.valid_i = 1'b0; bus.ready_i = 1'b1;
      wait (go_rand);
      while (chk_n < N_RAND && cyc < LIMIT) begin
        @(negedge clk);
        cyc++;
        bus.valid_i = (acc_n < N_RAND) && ($urandom_range(0, 9) < 7);
        bus.a_i     = pick();
        bus.b_i     = pick();
        bus.round_i = 1'($urandom_range(0, 1));
        bus.ready_i = ($urandom_range(0, 9) < 7);
        #1;
        if (bus.valid_i && bus.ready_o) begin
          q.push_back(ref_mul(bus.a_i, bus.b_i, bus.round_i, SG != 0));
          acc_n++;
        end
        if (bus.valid_o && bus.ready_i) begin
          if (q.size() == 0) begin
            fail($sformatf("rnd%0d_unexpected_output", g));
          end else begin
            e = q.pop_front();
            chk($sformatf("rnd%0d_p_%0d", g, chk_n), bus.p_o, e[7:0]);
`ifdef MUL_FRAC_OVF_EN
            chk($sformatf("rnd%0d_ovf_%0d", g, chk_n), ovf, e[8]);
            if (e[8] && ocnt < 65535) ocnt++;
`endif
          end
          chk_n++;
        end
      end
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b1;
      if (cyc >= LIMIT) fail($sformatf("rnd%0d_timeout", g));
      chk($sformatf("rnd%0d_leftover", g), q.size(), 0);
`ifdef MUL_FRAC_OVF_EN
      #1;
      chk($sformatf("rnd%0d_ovf_cnt", g), cnt, ocnt);
`endif
      done_cnt++;
    end
  end

endmodule
